// File: rtl/fma_pkg.sv
// fma_pkg: shared definitions for the FMA rounding/packing datapath.
//   round_mode_t - IEEE rounding mode encoding carried on in_rm.
//   FLAG_*       - bit positions inside the 3-bit {overflow, underflow, inexact} flag word.
//   inf_mag / maxnorm_mag - unsigned magnitude fields of +inf and +maxnorm
//                           for a given exponent/fraction width.
package fma_pkg;

    typedef enum logic [1:0] {
        RM_RZ  = 2'b00,
        RM_RNE = 2'b01,
        RM_RM  = 2'b10,
        RM_RP  = 2'b11
    } round_mode_t;

    localparam int unsigned FLAG_INX = 0;
    localparam int unsigned FLAG_UDF = 1;
    localparam int unsigned FLAG_OVF = 2;

    // Exponent all ones, fraction zero. Caller keeps the low ew+mw bits.
    function automatic logic [63:0] inf_mag(input int unsigned ew, input int unsigned mw);
        logic [63:0] e_ones;
        e_ones = (64'd1 << ew) - 64'd1;
        return e_ones << mw;
    endfunction

    // Largest finite exponent (all ones minus one) with an all-ones fraction.
    function automatic logic [63:0] maxnorm_mag(input int unsigned ew, input int unsigned mw);
        logic [63:0] e_max;
        logic [63:0] f_ones;
        e_max  = (64'd1 << ew) - 64'd2;
        f_ones = (64'd1 << mw) - 64'd1;
        return (e_max << mw) | f_ones;
    endfunction

endpackage

// File: rtl/round_decide.sv
// round_decide: combinational round-up decision.
//   sig     - normalised significand, bit IW-1 is the integer one.
//   sticky  - sticky from upstream alignment/addition.
//   sign    - result sign (selects direction for RM/RP).
//   rm      - rounding mode.
//   inc     - add one ulp to the kept MW+1 bits.
//   inexact - any discarded bit (guard, round or sticky) is set.
module round_decide
    import fma_pkg::*;
#(
    parameter int unsigned MW = 10,
    parameter int unsigned IW = 36
) (
    input  logic [IW-1:0] sig,
    input  logic          sticky,
    input  logic          sign,
    input  round_mode_t   rm,
    output logic          inc,
    output logic          inexact
);

    logic l;
    logic g;
    logic r;
    logic s;
    logic low_or;

    assign l = sig[IW-MW-1];
    assign g = sig[IW-MW-2];
    assign r = sig[IW-MW-3];

    // With IW == MW+3 there are no bits below the round bit.
    generate
        if (IW > MW + 3) begin : g_low
            assign low_or = |sig[IW-MW-4:0];
        end else begin : g_nolow
            assign low_or = 1'b0;
        end
    endgenerate

    assign s       = sticky | low_or;
    assign inexact = g | r | s;

    always_comb begin
        inc = 1'b0;
        unique case (rm)
            RM_RZ:  inc = 1'b0;
            RM_RNE: inc = g & (l | r | s);
            RM_RM:  inc = sign & (g | r | s);
            RM_RP:  inc = ~sign & (g | r | s);
            default: inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/round_pipe.sv
// round_pipe: two-stage valid/ready rounding and packing stage.
//   clk, reset_n        - clock, synchronous active-low reset.
//   in_valid/in_ready   - input handshake; in_ready is combinational from out_ready.
//   in_sign/in_exp/in_sig/in_sticky - normalised operand, in_exp is EW+2 bit two's complement.
//   in_rm               - rounding mode (00 RZ, 01 RNE, 10 RM, 11 RP).
//   in_special/in_special_val - bypass word emitted unrounded.
//   out_valid/out_ready - output handshake.
//   out_result          - packed {sign, exp, frac}.
//   out_flags           - {overflow, underflow, inexact}.
// Stage 1 takes the round-up decision, stage 2 applies it and packs.
module round_pipe
    import fma_pkg::*;
#(
    parameter int unsigned EW = 5,
    parameter int unsigned MW = 10,
    parameter int unsigned IW = 36
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EW+1:0]    in_exp,
    input  logic [IW-1:0]    in_sig,
    input  logic             in_sticky,
    input  logic [1:0]       in_rm,
    input  logic             in_special,
    input  logic [EW+MW:0]   in_special_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EW+MW:0]   out_result,
    output logic [2:0]       out_flags
);

    localparam logic [63:0]          INF64   = inf_mag(EW, MW);
    localparam logic [63:0]          MAX64   = maxnorm_mag(EW, MW);
    localparam logic [EW+MW-1:0]     INF_MAG = INF64[EW+MW-1:0];
    localparam logic [EW+MW-1:0]     MAX_MAG = MAX64[EW+MW-1:0];
    localparam logic signed [EW+2:0] E_OVF   = (EW+3)'((64'd1 << EW) - 64'd1);
    localparam logic signed [EW+2:0] E_ZERO  = '0;
    localparam logic signed [EW+2:0] E_ONE   = (EW+3)'(1);

    // ---------------- handshake ----------------
    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv    = ~s2_valid | out_ready;
    assign s1_adv    = ~s1_valid | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // ---------------- stage 1 ----------------
    round_mode_t     rm_in;
    logic            dec_inc;
    logic            dec_inx;

    logic            s1_sign;
    logic [EW+1:0]   s1_exp;
    logic [MW:0]     s1_k;
    logic            s1_inc;
    logic            s1_inx;
    round_mode_t     s1_rm;
    logic            s1_special;
    logic [EW+MW:0]  s1_special_val;

    assign rm_in = round_mode_t'(in_rm);

    round_decide #(
        .MW (MW),
        .IW (IW)
    ) u_decide (
        .sig     (in_sig),
        .sticky  (in_sticky),
        .sign    (in_sign),
        .rm      (rm_in),
        .inc     (dec_inc),
        .inexact (dec_inx)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid       <= 1'b0;
            s1_sign        <= 1'b0;
            s1_exp         <= '0;
            s1_k           <= '0;
            s1_inc         <= 1'b0;
            s1_inx         <= 1'b0;
            s1_rm          <= RM_RZ;
            s1_special     <= 1'b0;
            s1_special_val <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign        <= in_sign;
                s1_exp         <= in_exp;
                s1_k           <= in_sig[IW-1 -: MW+1];
                s1_inc         <= dec_inc;
                s1_inx         <= dec_inx;
                s1_rm          <= rm_in;
                s1_special     <= in_special;
                s1_special_val <= in_special_val;
            end
        end
    end

    // ---------------- stage 2 ----------------
    logic [MW+1:0]          m;
    logic [MW-1:0]          frac;
    logic signed [EW+2:0]   e;
    logic                   to_inf;
    logic [EW+MW:0]         res_next;
    logic [2:0]             flags_next;

    always_comb begin
        m          = {1'b0, s1_k} + {{(MW+1){1'b0}}, s1_inc};
        frac       = m[MW-1:0];
        // One extra exponent bit so exp+1 on carry-out cannot wrap.
        e          = $signed({s1_exp[EW+1], s1_exp});
        to_inf     = 1'b0;
        res_next   = '0;
        flags_next = '0;

        if (m[MW+1]) begin
            frac = m[MW:1];
            e    = e + E_ONE;
        end

        unique case (s1_rm)
            RM_RNE:  to_inf = 1'b1;
            RM_RP:   to_inf = ~s1_sign;
            RM_RM:   to_inf = s1_sign;
            default: to_inf = 1'b0;
        endcase

        if (s1_special) begin
            res_next = s1_special_val;
        end else if (e >= E_OVF) begin
            res_next             = {s1_sign, to_inf ? INF_MAG : MAX_MAG};
            flags_next[FLAG_OVF] = 1'b1;
            flags_next[FLAG_INX] = 1'b1;
        end else if (e <= E_ZERO) begin
            res_next             = {s1_sign, {(EW+MW){1'b0}}};
            flags_next[FLAG_UDF] = 1'b1;
            flags_next[FLAG_INX] = 1'b1;
        end else begin
            res_next             = {s1_sign, e[EW-1:0], frac};
            flags_next[FLAG_INX] = s1_inx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= res_next;
                out_flags  <= flags_next;
            end
        end
    end

endmodule
